// File: rtl/aging_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aging_priority_arbiter_if
// Brief    : Request/grant bundle between requesters, arbiter and consumer.
// Revision : 1.0
// ============================================================================
interface aging_priority_arbiter_if #(
    parameter int NUM_REQUESTS                 = 3,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64
);
    localparam int c_SRC_WIDTH = $clog2(NUM_REQUESTS);

    logic [NUM_REQUESTS*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_packed_in;
    logic [NUM_REQUESTS-1:0]                              request_valid_packed_in;
    logic [NUM_REQUESTS-1:0]                              request_critical_packed_in;
    logic [NUM_REQUESTS-1:0]                              issue_ack_out;
    logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]              request_out;
    logic                                                 request_valid_out;
    logic [c_SRC_WIDTH-1:0]                               request_source_out;
    logic                                                 issue_ack_in;

    // Environment side: requesters plus the downstream consumer.
    modport master (
        output request_packed_in,
        output request_valid_packed_in,
        output request_critical_packed_in,
        output issue_ack_in,
        input  issue_ack_out,
        input  request_out,
        input  request_valid_out,
        input  request_source_out
    );

    // Arbiter side.
    modport slave (
        input  request_packed_in,
        input  request_valid_packed_in,
        input  request_critical_packed_in,
        input  issue_ack_in,
        output issue_ack_out,
        output request_out,
        output request_valid_out,
        output request_source_out
    );
endinterface
`default_nettype wire

// File: rtl/aging_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aging_priority_arbiter
// Brief    : Aged > critical > round-robin arbiter feeding a one-entry stage.
// Revision : 1.0
// ============================================================================
module aging_priority_arbiter #(
    parameter int NUM_REQUESTS                 = 3,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int AGE_THRESHOLD                = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    aging_priority_arbiter_if.slave bus
);
    localparam int c_SRC_WIDTH = $clog2(NUM_REQUESTS);
    localparam int c_AGE_WIDTH = $clog2(AGE_THRESHOLD + 1);
    localparam int c_W         = SINGLE_REQUEST_WIDTH_IN_BITS;

    localparam logic [c_AGE_WIDTH-1:0] c_AGE_MAX  = c_AGE_WIDTH'(AGE_THRESHOLD);
    localparam logic [c_SRC_WIDTH-1:0] c_LAST_IDX = c_SRC_WIDTH'(NUM_REQUESTS - 1);
    localparam logic [c_SRC_WIDTH:0]   c_NUM_EXT  = (c_SRC_WIDTH + 1)'(NUM_REQUESTS);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [c_W-1:0]         r_request;
    logic [c_SRC_WIDTH-1:0] r_source;
    logic [c_SRC_WIDTH-1:0] r_rr_ptr;
    logic [c_AGE_WIDTH-1:0] r_age [NUM_REQUESTS];

    logic [NUM_REQUESTS-1:0]   w_aged;
    logic [NUM_REQUESTS-1:0]   w_crit;
    logic [NUM_REQUESTS-1:0]   w_norm;
    logic [c_W-1:0]            w_payload [NUM_REQUESTS];
    logic [2*NUM_REQUESTS-1:0] w_norm_dbl;
    logic [NUM_REQUESTS-1:0]   w_norm_rot;
    logic [c_SRC_WIDTH-1:0]    w_aged_idx;
    logic [c_SRC_WIDTH-1:0]    w_crit_idx;
    logic [c_SRC_WIDTH-1:0]    w_norm_off;
    logic [c_SRC_WIDTH:0]      w_norm_sum;
    logic [c_SRC_WIDTH-1:0]    w_norm_idx;
    logic [c_SRC_WIDTH-1:0]    w_winner;
    logic [c_SRC_WIDTH-1:0]    w_rr_next;
    logic                      w_norm_grant;
    logic                      w_any_valid;
    logic                      w_load;

    generate
        for (genvar gi = 0; gi < NUM_REQUESTS; gi++) begin : g_tier
            assign w_aged[gi] = bus.request_valid_packed_in[gi] & (r_age[gi] == c_AGE_MAX);
            assign w_crit[gi] = bus.request_valid_packed_in[gi] & bus.request_critical_packed_in[gi]
                                & ~w_aged[gi];
            assign w_norm[gi] = bus.request_valid_packed_in[gi] & ~bus.request_critical_packed_in[gi]
                                & ~w_aged[gi];
            assign w_payload[gi] = bus.request_packed_in[gi*c_W +: c_W];
        end
    endgenerate

    assign w_any_valid = |bus.request_valid_packed_in;
    assign w_load      = ((r_state == c_ST_EMPTY) || bus.issue_ack_in) && w_any_valid;

    // Rotating the normal vector by rr_ptr turns the wrap-around search into
    // a plain lowest-set-bit search; the offset is added back afterwards.
    assign w_norm_dbl = {w_norm, w_norm} >> r_rr_ptr;
    assign w_norm_rot = w_norm_dbl[NUM_REQUESTS-1:0];
    assign w_norm_sum = {1'b0, r_rr_ptr} + {1'b0, w_norm_off};
    assign w_norm_idx = (w_norm_sum >= c_NUM_EXT) ? c_SRC_WIDTH'(w_norm_sum - c_NUM_EXT)
                                                  : w_norm_sum[c_SRC_WIDTH-1:0];
    assign w_rr_next  = (w_winner == c_LAST_IDX) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_aged_idx = '0;
        w_crit_idx = '0;
        w_norm_off = '0;
        for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
            if (w_aged[i])     w_aged_idx = c_SRC_WIDTH'(i);
            if (w_crit[i])     w_crit_idx = c_SRC_WIDTH'(i);
            if (w_norm_rot[i]) w_norm_off = c_SRC_WIDTH'(i);
        end
    end

    always_comb begin
        w_winner     = w_norm_idx;
        w_norm_grant = 1'b1;
        if (|w_aged) begin
            w_winner     = w_aged_idx;
            w_norm_grant = 1'b0;
        end else if (|w_crit) begin
            w_winner     = w_crit_idx;
            w_norm_grant = 1'b0;
        end
    end

    // Output-stage FSM: state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output-stage FSM: next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_load) w_state_next = c_ST_FULL;
            c_ST_FULL:  if (bus.issue_ack_in && !w_any_valid) w_state_next = c_ST_EMPTY;
            default:    w_state_next = c_ST_EMPTY;
        endcase
    end

    // Output-stage FSM: outputs.
    always_comb begin
        bus.request_valid_out  = (r_state == c_ST_FULL);
        bus.request_out        = r_request;
        bus.request_source_out = r_source;
        bus.issue_ack_out      = '0;
        if (w_load && !reset_in) begin
            bus.issue_ack_out = NUM_REQUESTS'(1) << w_winner;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_request <= '0;
            r_source  <= '0;
            r_rr_ptr  <= '0;
        end else if (w_load) begin
            r_request <= w_payload[w_winner];
            r_source  <= w_winner;
            if (w_norm_grant) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Ages only advance on loads won by someone else, and saturate.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (reset_in) begin
                r_age[i] <= '0;
            end else if (!bus.request_valid_packed_in[i]
                         || (w_load && (w_winner == c_SRC_WIDTH'(i)))) begin
                r_age[i] <= '0;
            end else if (w_load && (r_age[i] != c_AGE_MAX)) begin
                r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aging_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aging_priority_arbiter
// Brief    : Vector table, directed corner sequences and random traffic.
// Revision : 1.0
// ============================================================================
module tb_aging_priority_arbiter;
    localparam int N  = 3;
    localparam int W  = 64;
    localparam int TH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aging_priority_arbiter_if #(.NUM_REQUESTS(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W)) bus ();

    aging_priority_arbiter #(
        .NUM_REQUESTS(N),
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .AGE_THRESHOLD(TH)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, priority chosen by a sort key.
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_rr;
    int           m_age [N];
    logic [W-1:0] cur_pay [N];

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] c;
        logic         a;
        logic [N-1:0] ack;
        logic         vout;
        logic [1:0]   src;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] c, output int tier);
        int best     = -1;
        int best_key = 1 << 30;
        int t;
        int key;
        tier = 2;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                t   = (m_age[i] >= TH) ? 0 : (c[i] ? 1 : 2);
                key = t * N + ((t == 2) ? (i - m_rr + N) % N : i);
                if (key < best_key) begin
                    best_key = key;
                    best     = i;
                    tier     = t;
                end
            end
        end
        return best;
    endfunction

    // One clock: drive, compare against model, then advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] c, input logic a, input logic r);
        int           w;
        int           tier;
        bit           load;
        logic [N-1:0] exp_ack;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) begin
            cur_pay[i] = {$urandom, $urandom};
            bus.request_packed_in[i*W +: W] = cur_pay[i];
        end
        bus.request_valid_packed_in    = v;
        bus.request_critical_packed_in = c;
        bus.issue_ack_in               = a;
        #1;
        w       = pick(v, c, tier);
        load    = (w >= 0) && (!m_full || a);
        exp_ack = (load && !r) ? (N'(1) << w) : '0;
        check("issue_ack_out", 64'(bus.issue_ack_out), 64'(exp_ack));
        check("request_valid_out", 64'(bus.request_valid_out), 64'(m_full));
        check("request_source_out", 64'(bus.request_source_out), 64'(m_src));
        check("request_out", bus.request_out, m_data);
        if (r) begin
            m_full = 1'b0;
            m_data = '0;
            m_src  = 0;
            m_rr   = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || (load && i == w)) m_age[i] = 0;
                else if (load && m_age[i] < TH) m_age[i]++;
            end
            if (load) begin
                m_full = 1'b1;
                m_data = cur_pay[w];
                m_src  = w;
                if (tier == 2) m_rr = (w + 1) % N;
            end else if (m_full && a) begin
                m_full = 1'b0;
            end
        end
    endtask

    initial begin
        int           exp_aging [10];
        logic [W-1:0] held;

        bus.request_packed_in          = '0;
        bus.request_valid_packed_in    = '0;
        bus.request_critical_packed_in = '0;
        bus.issue_ack_in               = 1'b0;
        m_full = 1'b0; m_data = '0; m_src = 0; m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;

        // Round robin, then critical overrides, then the resulting age promotions.
        tbl[0]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b0, 2'd0};
        tbl[1]  = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 2'd0};
        tbl[2]  = '{3'b111, 3'b000, 1'b1, 3'b100, 1'b1, 2'd1};
        tbl[3]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 2'd2};
        tbl[4]  = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 2'd0};
        tbl[5]  = '{3'b111, 3'b000, 1'b1, 3'b100, 1'b1, 2'd1};
        tbl[6]  = '{3'b111, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2};
        tbl[7]  = '{3'b111, 3'b110, 1'b1, 3'b010, 1'b1, 2'd2};
        tbl[8]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 2'd1};
        tbl[9]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0};
        tbl[10] = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 2'd0};
        tbl[11] = '{3'b111, 3'b000, 1'b1, 3'b100, 1'b1, 2'd1};

        step(3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b000, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].v, tbl[k].c, tbl[k].a, 1'b0);
            check("tbl_ack", 64'(bus.issue_ack_out), 64'(tbl[k].ack));
            check("tbl_vout", 64'(bus.request_valid_out), 64'(tbl[k].vout));
            check("tbl_src", 64'(bus.request_source_out), 64'(tbl[k].src));
        end

        // Critical stream on 0 lets normal requester 1 through every fifth grant.
        exp_aging = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        step(3'b000, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(3'b011, 3'b001, 1'b1, 1'b0);
            check("aging_grant", 64'(bus.issue_ack_out), 64'(N'(1) << exp_aging[k]));
        end

        // Stall with a full stage, then release.
        step(3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b111, 3'b000, 1'b1, 1'b0);
        held = cur_pay[0];
        for (int k = 0; k < 5; k++) begin
            step(3'b111, 3'b000, 1'b0, 1'b0);
            check("stall_ack", 64'(bus.issue_ack_out), 64'd0);
            check("stall_data", bus.request_out, held);
        end
        step(3'b111, 3'b000, 1'b1, 1'b0);
        check("release_ack", 64'(bus.issue_ack_out), 64'(3'b010));
        held = cur_pay[1];
        step(3'b000, 3'b000, 1'b0, 1'b0);
        check("release_data", bus.request_out, held);

        // Drain, then acknowledge while empty.
        step(3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b0);
        check("drain_vout", 64'(bus.request_valid_out), 64'd0);
        step(3'b000, 3'b000, 1'b0, 1'b0);
        check("empty_ack_vout", 64'(bus.request_valid_out), 64'd0);

        // Reset while full with non-zero ages.
        step(3'b111, 3'b001, 1'b1, 1'b0);
        step(3'b111, 3'b001, 1'b1, 1'b0);
        step(3'b111, 3'b000, 1'b1, 1'b1);
        check("reset_ack", 64'(bus.issue_ack_out), 64'd0);
        step(3'b111, 3'b000, 1'b1, 1'b0);
        check("post_reset_vout", 64'(bus.request_valid_out), 64'd0);
        check("post_reset_data", bus.request_out, 64'd0);
        check("post_reset_grant", 64'(bus.issue_ack_out), 64'(3'b001));

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            step(N'($urandom), N'($urandom) & N'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
